// File: rtl/fp_sqrt_pkg.sv
// Shared types and elaboration-time helpers for the iterative IEEE-754 square root.
package fp_sqrt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ITER,
    ROUND,
    PUT_Z
  } state_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } opclass_t;

  function automatic int unsigned fsq_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Root bits needed: hidden one + fraction + guard.
  function automatic int unsigned fsq_nbits(input int unsigned man_w);
    return man_w + 2;
  endfunction

  function automatic int unsigned fsq_steps(input int unsigned man_w, input int unsigned bpc);
    return (fsq_nbits(man_w) + bpc - 1) / bpc;
  endfunction

  // Canonical quiet NaN {0, all-ones exponent, 1, 0...}, right-aligned in 128 bits.
  function automatic logic [127:0] fsq_qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [127:0] v;
    v = '0;
    for (int unsigned i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sqrt_digit_step.sv
// One radix-2 restoring square-root digit: consumes two radicand bits, yields one root bit.
module sqrt_digit_step #(
  parameter int QW = 25,
  parameter int RW = QW + 2
) (
  input  logic [RW-1:0] i_rem,
  input  logic [QW-1:0] i_q,
  input  logic [1:0]    i_d,
  output logic [RW-1:0] o_rem,
  output logic          o_bit
);

  logic [RW+1:0] w_cur;
  logic [RW+1:0] w_sub;

  assign w_cur = {i_rem, i_d};
  assign w_sub = (RW+2)'({i_q, 2'b01});
  assign o_bit = (w_cur >= w_sub);
  assign o_rem = o_bit ? RW'(w_cur - w_sub) : RW'(w_cur);

endmodule

// File: rtl/fp_sqrt_iter.sv
// Iterative IEEE-754 square root with RNE rounding, DAZ, special bypass and stb/ack handshake.
module fp_sqrt_iter
  import fp_sqrt_pkg::*;
#(
  parameter int EXP_W        = 8,
  parameter int MAN_W        = 23,
  parameter int BITS_PER_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [EXP_W+MAN_W:0]     input_a,
  input  logic                     input_a_stb,
  output logic                     input_a_ack,
  output logic [EXP_W+MAN_W:0]     output_z,
  output logic                     output_z_stb,
  input  logic                     output_z_ack,
  output logic [1:0]               output_flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BIAS  = int'(fsq_bias(EXP_W));
  localparam int NBITS = int'(fsq_nbits(MAN_W));
  localparam int N     = int'(fsq_steps(MAN_W, BITS_PER_CYC));
  localparam int QW    = N * BITS_PER_CYC;
  localparam int PAD   = QW - NBITS;
  localparam int RW    = QW + 2;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;

  localparam logic [W-1:0]        QNAN_Z   = W'(fsq_qnan(EXP_W, MAN_W));
  localparam logic signed [EXP_W:0] BIAS_S = (EXP_W+1)'(BIAS);
  localparam logic [QW-1:0]       PAD_MASK = (QW'(1) << PAD) - QW'(1);

  state_t              r_state;
  logic                r_ack;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_z;
  logic                r_stb;
  logic [1:0]          r_flags;
  logic [CW-1:0]       r_cnt;
  logic [2*QW-1:0]     r_rad;
  logic [RW-1:0]       r_rem;
  logic [QW-1:0]       r_q;
  logic [EXP_W-1:0]    r_ze;

  // Operand decode
  logic                w_sign;
  logic [EXP_W-1:0]    w_exp;
  logic [MAN_W-1:0]    w_frac;
  opclass_t            w_cls;
  logic signed [EXP_W:0] w_e;
  logic signed [EXP_W:0] w_e_adj;
  logic signed [EXP_W:0] w_half;
  logic [NBITS-1:0]    w_m;
  logic [EXP_W-1:0]    w_ze;

  assign w_sign  = r_a[W-1];
  assign w_exp   = r_a[W-2:MAN_W];
  assign w_frac  = r_a[MAN_W-1:0];
  assign w_e     = $signed({1'b0, w_exp}) - BIAS_S;
  assign w_e_adj = w_e[0] ? (w_e - $signed((EXP_W+1)'(1))) : w_e;
  assign w_half  = w_e_adj >>> 1;
  assign w_ze    = EXP_W'(w_half + BIAS_S);
  assign w_m     = w_e[0] ? {1'b1, w_frac, 1'b0} : {2'b01, w_frac};

  // Classify the captured operand
  always_comb begin
    w_cls = CLS_NORM;
    if (w_exp == '0)             w_cls = CLS_ZERO;
    else if (w_exp == '1) begin
      if (w_frac == '0)          w_cls = CLS_INF;
      else if (w_frac[MAN_W-1])  w_cls = CLS_QNAN;
      else                       w_cls = CLS_SNAN;
    end
  end

  // Digit-step chain resolving BITS_PER_CYC root bits per cycle
  logic [RW-1:0] w_rem_c [0:BITS_PER_CYC];
  logic [QW-1:0] w_q_c   [0:BITS_PER_CYC];
  logic          w_bit   [0:BITS_PER_CYC-1];

  assign w_rem_c[0] = r_rem;
  assign w_q_c[0]   = r_q;

  for (genvar k = 0; k < BITS_PER_CYC; k++) begin : g_step
    sqrt_digit_step #(.QW(QW), .RW(RW)) u_step (
      .i_rem (w_rem_c[k]),
      .i_q   (w_q_c[k]),
      .i_d   (r_rad[2*QW-1-2*k -: 2]),
      .o_rem (w_rem_c[k+1]),
      .o_bit (w_bit[k])
    );
    assign w_q_c[k+1] = {w_q_c[k][QW-2:0], w_bit[k]};
  end

  // Rounding: any extra padded root bit folds into sticky
  logic [NBITS-1:0]  w_root;
  logic              w_sticky;
  logic              w_up;
  logic [MAN_W+1:0]  w_sum;
  logic              w_carry;
  logic [W-1:0]      w_round_z;

  assign w_root   = r_q[QW-1 -: NBITS];
  assign w_sticky = (r_rem != '0) || ((r_q & PAD_MASK) != '0);
  assign w_up     = w_root[0] & (w_root[1] | w_sticky);
  assign w_sum    = {1'b0, w_root[NBITS-1:1]} + (MAN_W+2)'(w_up);
  // significand is 01.x unless rounding carried into 10.0
  assign w_carry  = (w_sum[MAN_W+1:MAN_W] != 2'b01);
  assign w_round_z = w_carry ? {1'b0, r_ze + EXP_W'(1), {MAN_W{1'b0}}}
                             : {1'b0, r_ze, w_sum[MAN_W-1:0]};

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_a     <= '0;
      r_z     <= '0;
      r_stb   <= 1'b0;
      r_flags <= '0;
      r_cnt   <= '0;
      r_rad   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_ze    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_ack && input_a_stb) begin
            r_a     <= input_a;
            r_ack   <= 1'b0;
            r_state <= UNPACK;
          end else begin
            r_ack <= 1'b1;
          end
        end
        UNPACK: begin
          r_flags <= '0;
          if (w_cls == CLS_QNAN || w_cls == CLS_SNAN) begin
            r_z     <= QNAN_Z;
            r_flags <= {w_cls == CLS_SNAN, 1'b0};
            r_stb   <= 1'b1;
            r_state <= PUT_Z;
          end else if (w_sign && w_cls != CLS_ZERO) begin
            r_z     <= QNAN_Z;
            r_flags <= 2'b10;
            r_stb   <= 1'b1;
            r_state <= PUT_Z;
          end else if (w_cls == CLS_ZERO) begin
            r_z     <= {w_sign, {(W-1){1'b0}}};
            r_stb   <= 1'b1;
            r_state <= PUT_Z;
          end else if (w_cls == CLS_INF) begin
            r_z     <= r_a;
            r_stb   <= 1'b1;
            r_state <= PUT_Z;
          end else begin
            r_rad   <= {w_m, {(2*QW-NBITS){1'b0}}};
            r_rem   <= '0;
            r_q     <= '0;
            r_ze    <= w_ze;
            r_cnt   <= '0;
            r_state <= ITER;
          end
        end
        ITER: begin
          r_rad <= r_rad << (2 * BITS_PER_CYC);
          r_rem <= w_rem_c[BITS_PER_CYC];
          r_q   <= w_q_c[BITS_PER_CYC];
          if (r_cnt == CW'(N - 1)) r_state <= ROUND;
          else                     r_cnt   <= r_cnt + CW'(1);
        end
        ROUND: begin
          r_z     <= w_round_z;
          r_flags <= {1'b0, w_root[0] | w_sticky};
          r_stb   <= 1'b1;
          r_state <= PUT_Z;
        end
        PUT_Z: begin
          if (output_z_ack) begin
            r_stb   <= 1'b0;
            r_ack   <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign input_a_ack  = r_ack;
  assign output_z     = r_z;
  assign output_z_stb = r_stb;
  assign output_flags = r_flags;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Directed and randomised checks of fp_sqrt_iter in binary32/BPC=1 and binary16/BPC=2 form.
module tb_fp_sqrt_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] a32, z32;
  logic        a32_stb, a32_ack, z32_stb, z32_ack;
  logic [1:0]  f32;
  logic [15:0] a16, z16;
  logic        a16_stb, a16_ack, z16_stb, z16_ack;
  logic [1:0]  f16;

  fp_sqrt_iter u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .input_a(a32), .input_a_stb(a32_stb), .input_a_ack(a32_ack),
    .output_z(z32), .output_z_stb(z32_stb), .output_z_ack(z32_ack),
    .output_flags(f32)
  );

  fp_sqrt_iter #(.EXP_W(5), .MAN_W(10), .BITS_PER_CYC(2)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .input_a(a16), .input_a_stb(a16_stb), .input_a_ack(a16_ack),
    .output_z(z16), .output_z_stb(z16_stb), .output_z_ack(z16_ack),
    .output_flags(f16)
  );

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic g_ack(input bit h);
    return h ? a16_ack : a32_ack;
  endfunction
  function automatic logic g_stb(input bit h);
    return h ? z16_stb : z32_stb;
  endfunction
  function automatic logic [31:0] g_z(input bit h);
    return h ? {16'h0, z16} : z32;
  endfunction
  function automatic logic [1:0] g_f(input bit h);
    return h ? f16 : f32;
  endfunction

  task automatic set_in(input bit h, input logic stb, input logic [31:0] v);
    if (h) begin a16_stb = stb; a16 = v[15:0]; end
    else   begin a32_stb = stb; a32 = v;       end
  endtask
  task automatic set_zack(input bit h, input logic v);
    if (h) z16_ack = v; else z32_ack = v;
  endtask

  // Wait (bounded) for input ready, then transfer one operand
  task automatic op_start(input bit h, input logic [31:0] v, input string tag);
    int w = 0;
    while (!g_ack(h) && w < 50) begin @(posedge clk); #1; w++; end
    chk({tag, "/in_ack"}, 32'(g_ack(h)), 32'd1);
    set_in(h, 1'b1, v);
    @(posedge clk); #1;
    set_in(h, 1'b0, 32'd0);
    chk({tag, "/ack_drop"}, 32'(g_ack(h)), 32'd0);
  endtask

  task automatic wait_result(input bit h, input int exp_lat, input string tag);
    int lat = 0;
    while (!g_stb(h) && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic take(input bit h, input string tag);
    set_zack(h, 1'b1);
    @(posedge clk); #1;
    set_zack(h, 1'b0);
    chk({tag, "/stb_clr"}, 32'(g_stb(h)), 32'd0);
    chk({tag, "/ack_back"}, 32'(g_ack(h)), 32'd1);
  endtask

  task automatic run(input bit h, input logic [31:0] v, input logic [31:0] ez,
                     input logic [1:0] ef, input int lat, input string tag);
    op_start(h, v, tag);
    wait_result(h, lat, tag);
    chk({tag, "/z"}, g_z(h), ez);
    chk({tag, "/flags"}, 32'(g_f(h)), 32'(ef));
    take(h, tag);
  endtask

  // binary16 reference: integer sqrt by bit search, RNE by comparing against the midpoint square
  function automatic logic [18:0] ref16(input logic [15:0] a);
    logic s; logic [4:0] ex; logic [9:0] fr;
    int e; longint m, x, r, b;
    logic [15:0] z; logic [1:0] f; logic norm;
    s = a[15]; ex = a[14:10]; fr = a[9:0]; f = 2'b00; norm = 1'b0; z = 16'h0;
    if (ex == 5'h1F) begin
      if (fr != 0)  begin z = 16'h7E00; f = {~fr[9], 1'b0}; end
      else if (s)   begin z = 16'h7E00; f = 2'b10; end
      else          z = 16'h7C00;
    end else if (ex == 5'h00) begin
      z = {s, 15'h0};
    end else if (s) begin
      z = 16'h7E00; f = 2'b10;
    end else begin
      norm = 1'b1;
      e = int'(ex) - 15;
      m = 64'd1024 + longint'(fr);
      if (e % 2 != 0) begin m = m * 2; e = e - 1; end
      x = m * 1024;
      r = 0;
      for (int bi = 11; bi >= 0; bi--) begin
        b = r + (longint'(1) << bi);
        if (b * b <= x) r = b;
      end
      f[0] = (r * r != x);
      if (4 * x > (2 * r + 1) * (2 * r + 1)) r++;
      e = e / 2 + 15;
      if (r == 2048) begin r = 1024; e++; end
      z = {1'b0, 5'(e), 10'(r - 1024)};
    end
    return {norm, f, z};
  endfunction

  initial begin
    logic [31:0] hz;
    logic [1:0]  hf;
    logic        seen;
    logic [15:0] rv;
    logic [18:0] rr;

    rst_n = 1'b0;
    a32 = '0; a32_stb = 1'b0; z32_ack = 1'b0;
    a16 = '0; a16_stb = 1'b0; z16_ack = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst/ack32", 32'(a32_ack), 32'd0);
    chk("rst/stb32", 32'(z32_stb), 32'd0);
    chk("rst/z32", z32, 32'd0);
    chk("rst/flags32", 32'(f32), 32'd0);
    chk("rst/ack16", 32'(a16_ack), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel/ack32", 32'(a32_ack), 32'd1);
    chk("rel/ack16", 32'(a16_ack), 32'd1);

    // binary32 normal path and specials
    run(1'b0, 32'h40800000, 32'h40000000, 2'b00, 27, "sqrt4");
    run(1'b0, 32'h40000000, 32'h3FB504F3, 2'b01, 27, "sqrt2");
    run(1'b0, 32'h3F800000, 32'h3F800000, 2'b00, 27, "sqrt1");
    run(1'b0, 32'hBF800000, 32'h7FC00000, 2'b10, 1,  "neg1");
    run(1'b0, 32'h7F800001, 32'h7FC00000, 2'b10, 1,  "snan");
    run(1'b0, 32'h7FC00001, 32'h7FC00000, 2'b00, 1,  "qnan");
    run(1'b0, 32'hFF800000, 32'h7FC00000, 2'b10, 1,  "neginf");
    run(1'b0, 32'h7F800000, 32'h7F800000, 2'b00, 1,  "posinf");
    run(1'b0, 32'h80000000, 32'h80000000, 2'b00, 1,  "negzero");
    run(1'b0, 32'h00000001, 32'h00000000, 2'b00, 1,  "subnorm");
    run(1'b0, 32'h3E800000, 32'h3F000000, 2'b00, 27, "quarter");

    // Backpressure: result held while consumer stalls
    op_start(1'b0, 32'h40000000, "bp");
    wait_result(1'b0, 27, "bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp/z", z32, 32'h3FB504F3);
      chk("bp/flags", 32'(f32), 32'd1);
      chk("bp/stb", 32'(z32_stb), 32'd1);
      chk("bp/in_ack", 32'(a32_ack), 32'd0);
    end
    take(1'b0, "bp");
    run(1'b0, 32'h41100000, 32'h40400000, 2'b00, 27, "bp_next");

    // Reset mid-iteration aborts without a stale result
    op_start(1'b0, 32'h40800000, "abort");
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort/stb", 32'(z32_stb), 32'd0);
    chk("abort/ack", 32'(a32_ack), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; seen = seen | z32_stb; end
    chk("abort/no_stale", 32'(seen), 32'd0);
    run(1'b0, 32'h41100000, 32'h40400000, 2'b00, 27, "after_abort");

    // binary16, two root bits per cycle
    run(1'b1, 32'h4400, 32'h4000, 2'b00, 8, "h_sqrt4");
    run(1'b1, 32'h4000, 32'h3DA8, 2'b01, 8, "h_sqrt2");
    run(1'b1, 32'hFC00, 32'h7E00, 2'b10, 1, "h_neginf");

    // binary16 random sweep against the reference model
    for (int i = 0; i < 200; i++) begin
      rv = 16'($urandom);
      if (i % 4 == 0) rv[15] = 1'b0;
      rr = ref16(rv);
      hz = {16'h0, rr[15:0]};
      hf = rr[17:16];
      run(1'b1, {16'h0, rv}, hz, hf, rr[18] ? 8 : 1, $sformatf("rnd%0d_%h", i, rv));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
